// File: rtl/uart_tx_scheduler_if.sv
// Requester-side byte-stream bundle for uart_tx_scheduler: per-requester
// valid/last/data toward the scheduler, one-hot ready back.
interface uart_tx_scheduler_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_last;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_last, output req_data, input req_ready);
  modport slave  (input req_valid, input req_last, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin sequencer sharing one uart TX FIFO among N_REQ byte streams.
// Define UART_SCHED_PRIO_EN to give requester 0 absolute priority at arbitration.
module uart_tx_scheduler #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_tx_scheduler_if.slave       req_if,
  input  logic                     uart_fifo_full,
  output logic [7:0]               pc_in_t,
  output logic                     wr_en,
  output logic                     start_tx,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);
  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] BCAP = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] TCAP = TW'(IDLE_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_KICK = 2'd2;

  logic [1:0]    state;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] tcnt;
  logic          own_valid;
  logic          own_last;
  logic          found;
  logic [GW-1:0] pick;
  logic [GW-1:0] idx;

  assign busy = (state != S_IDLE);

  always_comb begin
    own_valid        = req_if.req_valid[grant_id];
    own_last         = req_if.req_last[grant_id];
    req_if.req_ready = '0;
    wr_en            = 1'b0;
    pc_in_t          = '0;
    if (state == S_XFER) begin
      req_if.req_ready[grant_id] = ~uart_fifo_full;
      wr_en                      = own_valid & ~uart_fifo_full;
      pc_in_t                    = req_if.req_data[{grant_id, 3'b000} +: 8];
    end
  end

  // Search starts one past the last owner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = grant_id;
    idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = GW'((32'(grant_id) + i) % N_REQ);
      if (!found && req_if.req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
`ifdef UART_SCHED_PRIO_EN
    if (req_if.req_valid[0]) begin
      found = 1'b1;
      pick  = '0;
    end
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      grant_id <= GW'(N_REQ - 1);
      bcnt     <= '0;
      tcnt     <= '0;
      start_tx <= 1'b0;
    end else begin
      start_tx <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_id <= pick;
            state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (wr_en) begin
            bcnt <= bcnt + 1'b1;
            tcnt <= '0;
            if (own_last || bcnt == BCAP) begin
              state    <= S_KICK;
              start_tx <= 1'b1;
            end
          end else if (!own_valid) begin
            // A stall (valid high, FIFO full) leaves the timeout untouched.
            if (tcnt == TCAP) begin
              tcnt     <= '0;
              state    <= (bcnt != '0) ? S_KICK : S_IDLE;
              start_tx <= (bcnt != '0);
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        S_KICK: begin
          bcnt  <= '0;
          tcnt  <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
